// File: rtl/vga_fill_ctrl.sv
// Rectangle fill controller for a VGA frame buffer.
// Accepts one fill command through a valid/ready handshake. It then writes
// one pixel per cycle in row-major order, then pulses done.
// Optional clipping is enabled with macro VGA_FILL_CLIP_EN. When it is set,
// captured coordinates are clamped to H_MAX / V_MAX.
module vga_fill_ctrl #(
  parameter int H_MAX = 159,
  parameter int V_MAX = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x0,
  input  logic [7:0] cmd_x1,
  input  logic [6:0] cmd_y0,
  input  logic [6:0] cmd_y1,
  input  logic [2:0] cmd_color,
  input  logic       abort,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t     state_q;
  logic [7:0] x_q, x0_q, x1_q;
  logic [6:0] y_q, y1_q;
  logic [2:0] color_q;
  logic       plot_q, busy_q, done_q;

  // Command coordinates after optional clamping; these are the values captured.
  logic [7:0] cx0, cx1;
  logic [6:0] cy0, cy1;
  logic       cmd_ok;

`ifdef VGA_FILL_CLIP_EN
  localparam logic [7:0] HM = 8'(H_MAX);
  localparam logic [6:0] VM = 7'(V_MAX);

  // Clamp every corner into the visible area so no off-screen write can occur.
  always_comb begin
    cx0 = (cmd_x0 > HM) ? HM : cmd_x0;
    cx1 = (cmd_x1 > HM) ? HM : cmd_x1;
    cy0 = (cmd_y0 > VM) ? VM : cmd_y0;
    cy1 = (cmd_y1 > VM) ? VM : cmd_y1;
  end
`else
  // Coordinates pass through untouched; range checking is left to the caller.
  always_comb begin
    cx0 = cmd_x0;
    cx1 = cmd_x1;
    cy0 = cmd_y0;
    cy1 = cmd_y1;
  end

  logic unused_params;
  assign unused_params = ^{8'(H_MAX), 7'(V_MAX)};
`endif

  assign cmd_ok    = (cx0 <= cx1) && (cy0 <= cy1);
  assign cmd_ready = (state_q == S_IDLE);

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // Fill FSM with registered outputs.
  // Counters only ever step up to the captured bound, so 8/7 bits never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (cmd_valid) begin
            busy_q <= 1'b1;
            if (cmd_ok) begin
              state_q <= S_FILL;
              x_q     <= cx0;
              y_q     <= cy0;
              x0_q    <= cx0;
              x1_q    <= cx1;
              y1_q    <= cy1;
              color_q <= cmd_color;
              plot_q  <= 1'b1;
            end else begin
              // Empty rectangle: skip straight to the completion pulse.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (abort) begin
            state_q <= S_IDLE;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (x_q == x1_q) begin
            if (y_q == y1_q) begin
              state_q <= S_DONE;
              plot_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q <= x0_q;
              y_q <= y_q + 7'd1;
            end
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
